mdu_sequencer: RTL

- Iterative multiply/divide sequencer for the MIPS execute stage; handles MULT, MULTU, DIV and DIVU.
- Owns the architectural HI/LO registers.
- Runs a one-bit-per-cycle shift-add / restoring-subtract datapath over 32 iterations, with sign pre/post-processing.
- The execute stage issues through a valid/ready handshake and stalls on busy. The sequencer aborts on cancel (exception or flush).

---
 rtl/mdu_sequencer_if.sv | 29 ++
 rtl/mdu_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mdu_sequencer_if.sv
// Issue/result bundle between the execute stage and the multiply/divide sequencer.
// The execute stage drives the master side; the sequencer sits on the slave side.
interface mdu_sequencer_if #(
   parameter int DW = 32
);
   logic          op_valid;
   logic          op_ready;
   logic [1:0]    op_code;
   logic [DW-1:0] src_a;
   logic [DW-1:0] src_b;
   logic          cancel;
   logic          hi_we;
   logic          lo_we;
   logic [DW-1:0] wdata;
   logic          busy;
   logic          done;
   logic [DW-1:0] hi;
   logic [DW-1:0] lo;

   modport master (
      output op_valid, op_code, src_a, src_b, cancel, hi_we, lo_we, wdata,
      input  op_ready, busy, done, hi, lo
   );

   modport slave (
      input  op_valid, op_code, src_a, src_b, cancel, hi_we, lo_we, wdata,
      output op_ready, busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle over DW iterations,
// with sign magnitude pre-processing and a single negate fixup cycle.
module mdu_sequencer #(
   parameter int DW = 32
) (
   input  logic           clk,
   input  logic           resetn,
   mdu_sequencer_if.slave bus
);
   localparam int CW = $clog2(DW);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t          r_state;
   logic [1:0]      r_op;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic            r_neg_q;
   logic            r_neg_r;
   logic [CW-1:0]   r_cnt;
   logic [2*DW-1:0] r_prod;
   logic [DW-1:0]   r_hi;
   logic [DW-1:0]   r_lo;
   logic            r_done;

   logic            w_is_div;
   logic            w_use_sign;
   logic [DW-1:0]   w_mag_a;
   logic [DW-1:0]   w_mag_b;
   logic [DW:0]     w_mul_sum;
   logic [DW:0]     w_div_shift;
   logic            w_no_borrow;
   logic [DW-1:0]   w_div_diff;
   logic [2*DW-1:0] w_iter_next;
   logic [2*DW-1:0] w_prod_fix;
   logic [DW-1:0]   w_quo_fix;
   logic [DW-1:0]   w_rem_fix;

   assign w_is_div = r_op[1];

   // A zero divisor skips magnitude/sign handling so the raw dividend lands in HI untouched.
   assign w_use_sign = ~r_op[0] & ~(w_is_div & (r_b == '0));
   assign w_mag_a    = (w_use_sign & r_a[DW-1]) ? -r_a : r_a;
   assign w_mag_b    = (w_use_sign & r_b[DW-1]) ? -r_b : r_b;

   assign w_mul_sum   = {1'b0, r_prod[2*DW-1:DW]} + (r_prod[0] ? {1'b0, r_a} : {(DW+1){1'b0}});
   assign w_div_shift = r_prod[2*DW-1:DW-1];
   assign w_no_borrow = (w_div_shift >= {1'b0, r_b});
   assign w_div_diff  = w_div_shift[DW-1:0] - r_b;

   // Divide keeps remainder in the upper half and dividend/quotient in the lower half.
   assign w_iter_next = w_is_div
      ? {(w_no_borrow ? w_div_diff : w_div_shift[DW-1:0]), r_prod[DW-2:0], w_no_borrow}
      : {w_mul_sum, r_prod[DW-1:1]};

   assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
   assign w_quo_fix  = r_neg_q ? -r_prod[DW-1:0] : r_prod[DW-1:0];
   assign w_rem_fix  = r_neg_r ? -r_prod[2*DW-1:DW] : r_prod[2*DW-1:DW];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_cnt   <= '0;
         r_prod  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.hi_we) r_hi <= bus.wdata;
               if (bus.lo_we) r_lo <= bus.wdata;
               if (bus.op_valid && !bus.cancel) begin
                  r_op    <= bus.op_code;
                  r_a     <= bus.src_a;
                  r_b     <= bus.src_b;
                  r_state <= S_PREP;
               end
            end
            S_PREP: begin
               if (bus.cancel) begin
                  r_state <= S_IDLE;
               end else begin
                  r_a     <= w_mag_a;
                  r_b     <= w_mag_b;
                  r_neg_q <= w_use_sign & (r_a[DW-1] ^ r_b[DW-1]);
                  r_neg_r <= w_use_sign & r_a[DW-1] & w_is_div;
                  r_prod  <= w_is_div ? {{DW{1'b0}}, w_mag_a} : {{DW{1'b0}}, w_mag_b};
                  r_cnt   <= '0;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               if (bus.cancel) begin
                  r_state <= S_IDLE;
               end else begin
                  r_prod <= w_iter_next;
                  r_cnt  <= r_cnt + CW'(1);
                  if (r_cnt == CW'(DW-1)) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (bus.cancel) begin
                  r_state <= S_IDLE;
               end else begin
                  if (w_is_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*DW-1:DW];
                     r_lo <= w_prod_fix[DW-1:0];
                  end
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.op_ready = (r_state == S_IDLE);
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
endmodule
